// File: rtl/bdc_pkg.sv
// Shared BDC definitions: opcode bytes, command sequencer states and the
// host command record latched by bdc_cmd_sequencer.
package bdc_pkg;

    localparam logic [7:0] BACKGROUND    = 8'h90;
    localparam logic [7:0] READ_STATUS   = 8'hE4;
    localparam logic [7:0] WRITE_CONTROL = 8'hC4;
    localparam logic [7:0] READ_BYTE     = 8'hE0;
    localparam logic [7:0] WRITE_BYTE    = 8'hC0;
    localparam logic [7:0] GO            = 8'h08;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        DELAY  = 3'd4,
        RESP   = 3'd5
    } bdc_state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] addr;
        logic        has_addr;
        logic        has_wr;
        logic [7:0]  wdata;
        logic        has_rd;
    } bdc_cmd_t;

endpackage

// File: rtl/bdc_cmd_sequencer.sv
// Runs one BDC command (opcode, optional address/write byte, target-clock
// delay, optional read) over a byte-level bdc_interface and returns one response.
module bdc_cmd_sequencer
    import bdc_pkg::*;
#(
    parameter int DELAY_TCYC  = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_opcode,
    input  logic [15:0] cmd_addr,
    input  logic       cmd_has_addr,
    input  logic       cmd_has_wr,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_has_rd,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       tgt_clk_pulse,
    output logic [7:0] bdc_wdata,
    output logic       bdc_send,
    output logic       bdc_read,
    input  logic [7:0] bdc_rdata,
    input  logic       bdc_ready,
    output bdc_state_e state_dbg
);

    localparam int DW = $clog2(DELAY_TCYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DW-1:0] DLY_MAX  = DW'(DELAY_TCYC);
    localparam logic [DW-1:0] DLY_LAST = DW'(DELAY_TCYC - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC);

    bdc_state_e      state, next_state;
    bdc_cmd_t        cmd_in;
    logic [3:0][7:0] byte_list, list_d;
    logic [1:0]      idx, last_idx, last_d;
    logic            rd_req, rd_phase, dly_first;
    logic [DW-1:0]   dly_cnt;
    logic [TW-1:0]   tmo_cnt;

    logic       accept, strobe_send, strobe_read, idx_inc, capture, tmo_hit;
    logic       dly_count, dly_hit;
    logic [7:0] wdata_d;

    // Host handshake: a command transfers on a cycle with cmd_valid && cmd_ready;
    // cmd_ready is high exactly while IDLE, so busy-time offers are simply held off.
    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_ready && cmd_valid;
    assign state_dbg = state;

    assign cmd_in = '{opcode:   cmd_opcode,
                      addr:     cmd_addr,
                      has_addr: cmd_has_addr,
                      has_wr:   cmd_has_wr,
                      wdata:    cmd_wdata,
                      has_rd:   cmd_has_rd};

    always_comb begin
        list_d    = '0;
        list_d[0] = cmd_in.opcode;
        last_d    = 2'd0;
        if (cmd_in.has_addr) begin
            list_d[1] = cmd_in.addr[15:8];
            list_d[2] = cmd_in.addr[7:0];
            last_d    = 2'd2;
        end
        if (cmd_in.has_wr) begin
            if (cmd_in.has_addr) begin
                list_d[3] = cmd_in.wdata;
                last_d    = 2'd3;
            end else begin
                list_d[1] = cmd_in.wdata;
                last_d    = 2'd1;
            end
        end
    end

    // The pulse seen in the first DELAY cycle is deliberately not counted.
    assign dly_count = (state == DELAY) && !dly_first && tgt_clk_pulse;
    assign dly_hit   = dly_count && (dly_cnt == DLY_LAST);

    always_comb begin
        next_state  = state;
        strobe_send = 1'b0;
        strobe_read = 1'b0;
        idx_inc     = 1'b0;
        capture     = 1'b0;
        tmo_hit     = 1'b0;
        wdata_d     = bdc_wdata;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    strobe_send = 1'b1;
                    wdata_d     = list_d[0];
                    next_state  = ISSUE;
                end
            end
            ISSUE:  next_state = SETTLE;
            SETTLE: next_state = WAIT;
            WAIT: begin
                if (bdc_ready) begin
                    if (rd_phase) begin
                        capture    = 1'b1;
                        next_state = RESP;
                    end else if (idx == last_idx) begin
                        next_state = DELAY;
                    end else begin
                        idx_inc     = 1'b1;
                        strobe_send = 1'b1;
                        wdata_d     = byte_list[idx + 2'd1];
                        next_state  = ISSUE;
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    tmo_hit    = 1'b1;
                    next_state = RESP;
                end
            end
            DELAY: begin
                if (dly_hit) begin
                    if (rd_req) begin
                        strobe_read = 1'b1;
                        next_state  = ISSUE;
                    end else begin
                        next_state = RESP;
                    end
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_list <= '0;
            idx       <= 2'd0;
            last_idx  <= 2'd0;
            rd_req    <= 1'b0;
            rd_phase  <= 1'b0;
        end else begin
            if (accept) begin
                byte_list <= list_d;
                idx       <= 2'd0;
                last_idx  <= last_d;
                rd_req    <= cmd_in.has_rd;
                rd_phase  <= 1'b0;
            end else begin
                if (idx_inc) idx <= idx + 2'd1;
                if (strobe_read) rd_phase <= 1'b1;
            end
        end
    end

    // Per-byte watchdog restarts on every strobe and runs through SETTLE and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt   <= '0;
            dly_cnt   <= '0;
            dly_first <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if ((state == SETTLE || state == WAIT) && tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state != DELAY && next_state == DELAY) begin
                dly_first <= 1'b1;
                dly_cnt   <= '0;
            end else if (state == DELAY) begin
                dly_first <= 1'b0;
                if (dly_count && dly_cnt != DLY_MAX) dly_cnt <= dly_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bdc_wdata <= 8'h00;
            bdc_send  <= 1'b0;
            bdc_read  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            bdc_wdata <= wdata_d;
            bdc_send  <= strobe_send;
            bdc_read  <= strobe_read;
            rsp_valid <= (next_state == RESP);
            if (next_state == RESP) begin
                rsp_data <= capture ? bdc_rdata : 8'h00;
                rsp_err  <= tmo_hit;
            end
        end
    end

endmodule

// File: tb/tb_bdc_cmd_sequencer.sv
// Randomized bench for bdc_cmd_sequencer: a behavioural bdc_interface and
// target clock drive the DUT while a cycle-level reference predicts every strobe.
module tb_bdc_cmd_sequencer;
    import bdc_pkg::*;

    localparam int DELAY_TCYC  = 16;
    localparam int TIMEOUT_CYC = 100;
    localparam logic [2:0] EV_SEND = 3'b001;
    localparam logic [2:0] EV_READ = 3'b010;
    localparam logic [2:0] EV_RSP  = 3'b100;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready;
    logic [7:0] cmd_opcode, cmd_wdata;
    logic [15:0] cmd_addr;
    logic       cmd_has_addr, cmd_has_wr, cmd_has_rd;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_data;
    logic       tgt_clk_pulse;
    logic [7:0] bdc_wdata, bdc_rdata;
    logic       bdc_send, bdc_read, bdc_ready;
    bdc_state_e state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rsp_cyc = -100;

    logic [7:0] exp_q[$];
    int         rdy_timer   = 0;
    bit         stall_read  = 0;
    bit         ready_rose  = 0;
    bit         force_pulse = 0;
    logic [7:0] rd_value    = 8'h00;

    bdc_cmd_sequencer #(.DELAY_TCYC(DELAY_TCYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
        .cmd_has_addr(cmd_has_addr), .cmd_has_wr(cmd_has_wr),
        .cmd_wdata(cmd_wdata), .cmd_has_rd(cmd_has_rd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tgt_clk_pulse(tgt_clk_pulse),
        .bdc_wdata(bdc_wdata), .bdc_send(bdc_send), .bdc_read(bdc_read),
        .bdc_rdata(bdc_rdata), .bdc_ready(bdc_ready),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, want, cyc);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge, DUT outputs are stable then.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        ready_rose = 0;
        bdc_rdata  = 8'($urandom);
        if (bdc_send || bdc_read) begin
            bdc_ready = 1'b0;
            rdy_timer = (bdc_read && stall_read) ? 0 : int'($urandom_range(2, 6));
        end else if (rdy_timer > 0) begin
            rdy_timer--;
            if (rdy_timer == 0) begin
                bdc_ready  = 1'b1;
                ready_rose = 1;
                bdc_rdata  = rd_value;
            end
        end
        tgt_clk_pulse = force_pulse || ($urandom_range(0, 2) == 0);
        force_pulse   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check({tag, "_bdc_send"},  32'(bdc_send),  32'd0);
        check({tag, "_bdc_read"},  32'(bdc_read),  32'd0);
        check({tag, "_bdc_wdata"}, 32'(bdc_wdata), 32'd0);
        check({tag, "_state"},     32'(state_dbg), 32'(IDLE));
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [15:0] addr, input bit ha,
                           input bit hw, input logic [7:0] wd, input bit hr,
                           input logic [7:0] rdv, input bit stall, input bit keep_valid,
                           input bit b2b, input int abort_after);
        int exp_cyc, dly_from, dly_cnt, phase, budget, sends;
        logic [2:0] want, obs;
        logic [7:0] exp_data;
        logic       exp_err;
        bit         done;
        exp_q.delete();
        exp_q.push_back(op);
        if (ha) begin
            exp_q.push_back(addr[15:8]);
            exp_q.push_back(addr[7:0]);
        end
        if (hw) exp_q.push_back(wd);
        rd_value   = rdv;
        stall_read = stall;
        exp_data   = hr ? rdv : 8'h00;
        exp_err    = 1'b0;
        cmd_opcode = op; cmd_addr = addr; cmd_has_addr = ha;
        cmd_has_wr = hw; cmd_wdata = wd; cmd_has_rd = hr;
        cmd_valid  = 1'b1;
        budget = 0;
        while (!cmd_ready && budget < 50) begin
            step();
            budget++;
        end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        if (b2b) check("b2b_accept_gap", 32'(cyc - last_rsp_cyc), 32'd1);
        exp_cyc  = cyc + 1;
        want     = EV_SEND;
        phase    = 0;
        dly_from = 0;
        dly_cnt  = 0;
        sends    = 0;
        done     = 0;
        step();
        if (keep_valid) begin
            cmd_opcode = 8'($urandom); cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
            cmd_has_addr = 1'($urandom); cmd_has_wr = 1'($urandom); cmd_has_rd = 1'($urandom);
        end else begin
            cmd_valid = 1'b0;
        end
        for (int n = 0; n < 3000 && !done; n++) begin
            if (n > 0) step();
            obs = {rsp_valid, bdc_read, bdc_send};
            if (obs != 3'b000 || cyc == exp_cyc)
                check("strobes", 32'(obs), 32'((cyc == exp_cyc) ? want : 3'b000));
            if (bdc_send && exp_q.size() > 0) begin
                sends++;
                check("send_byte", 32'(bdc_wdata), 32'(exp_q.pop_front()));
            end
            if (abort_after > 0 && sends == abort_after) return;
            if (bdc_read && stall) begin
                exp_cyc  = cyc + TIMEOUT_CYC + 2;
                want     = EV_RSP;
                exp_err  = 1'b1;
                exp_data = 8'h00;
            end
            if (ready_rose) begin
                if (phase == 0 && exp_q.size() > 0) begin
                    exp_cyc = cyc + 1;
                    want    = EV_SEND;
                end else if (phase == 0) begin
                    phase       = 1;
                    dly_from    = cyc + 2;
                    dly_cnt     = 0;
                    force_pulse = 1;
                end else if (phase == 2) begin
                    exp_cyc = cyc + 1;
                    want    = EV_RSP;
                end
            end
            if (phase == 1 && cyc >= dly_from && tgt_clk_pulse) begin
                dly_cnt++;
                if (dly_cnt == DELAY_TCYC) begin
                    exp_cyc = cyc + 1;
                    want    = hr ? EV_READ : EV_RSP;
                    phase   = hr ? 2 : 3;
                end
            end
            if (rsp_valid) begin
                check("rsp_err",     32'(rsp_err),   32'(exp_err));
                check("rsp_data",    32'(rsp_data),  32'(exp_data));
                check("busy_on_rsp", 32'(cmd_ready), 32'd0);
                last_rsp_cyc = cyc;
                done = 1;
            end
        end
        check("cmd_finished", 32'(done), 32'd1);
    endtask

    initial begin
        logic [7:0] ops[6];
        ops = '{BACKGROUND, READ_STATUS, WRITE_CONTROL, READ_BYTE, WRITE_BYTE, GO};
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_addr = 16'h0000; cmd_wdata = 8'h00;
        cmd_has_addr = 1'b0; cmd_has_wr = 1'b0; cmd_has_rd = 1'b0;
        tgt_clk_pulse = 1'b0; bdc_rdata = 8'h00; bdc_ready = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (3) step();
        rst = 1'b1;
        step();

        run_cmd(WRITE_BYTE, 16'h1234, 1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 0);
        run_cmd(READ_BYTE, 16'h0080, 1, 0, 8'h00, 1, 8'hA7, 0, 0, 0, 0);
        run_cmd(BACKGROUND, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);

        run_cmd(READ_STATUS, 16'h0000, 0, 0, 8'h00, 1, 8'h3C, 1, 0, 0, 0);
        step();
        check("ready_after_timeout", 32'(cmd_ready), 32'd1);
        stall_read = 0;

        run_cmd(WRITE_CONTROL, 16'h0000, 0, 1, 8'h81, 0, 8'h00, 0, 1, 0, 0);
        run_cmd(READ_BYTE, 16'hBEEF, 1, 0, 8'h00, 1, 8'h5C, 0, 0, 1, 0);

        run_cmd(WRITE_BYTE, 16'hCAFE, 1, 1, 8'h77, 0, 8'h00, 0, 0, 0, 2);
        #2;
        rst = 1'b0;
        rdy_timer = 0;
        bdc_ready = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_no_rsp",  32'(rsp_valid), 32'd0);
            check("rst_no_send", 32'(bdc_send),  32'd0);
        end
        rst = 1'b1;
        step();
        run_cmd(READ_BYTE, 16'h4321, 1, 0, 8'h00, 1, 8'hD2, 0, 0, 0, 0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(ops[$urandom_range(0, 5)], 16'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 1'($urandom), 8'($urandom), 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
